lsu_ctrl: RTL and testbench

//  Load/store unit downstream of the ALU in the EX->MEM path. Takes the ALU result as
//  the effective address, runs one req/ack transaction on the data-memory bus, and

---
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one req/ack data-memory transaction per EX request, with extended load return.
// Latency: decode error -> done in cycle 1; ack in first ACCESS cycle -> done in cycle 2.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_lsu_valid,
   input  logic        i_lsu_wren,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_alu_data,
   input  logic [31:0] i_st_data,
   output logic        o_lsu_stall,
   output logic        o_lsu_done,
   output logic [31:0] o_ld_data,
   output logic        o_lsu_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    off_q, off_d;
   logic [2:0]    f3_q, f3_d;
   logic          req_q, req_d, we_q, we_d, done_q, done_d, err_q, err_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
   logic [3:0]    be_q, be_d;

   logic [1:0]    a_lo;
   logic          dec_err;
   logic [3:0]    dec_be;
   logic [15:0]   r_lo;
   logic [31:0]   ld_ext;

   assign a_lo = i_alu_data[1:0];

   always_comb begin
      dec_err = 1'b1;
      case (i_funct3)
         3'b000:  dec_err = 1'b0;
         3'b001:  dec_err = a_lo[0];
         3'b010:  dec_err = |a_lo;
         3'b100:  dec_err = i_lsu_wren;
         3'b101:  dec_err = i_lsu_wren | a_lo[0];
         default: dec_err = 1'b1;
      endcase
      dec_be = 4'b1111;
      case (i_funct3[1:0])
         2'b00:   dec_be = 4'b0001 << a_lo;
         2'b01:   dec_be = 4'b0011 << a_lo;
         default: dec_be = 4'b1111;
      endcase
   end

   // Load extraction uses the offset/size latched at decode, not the live EX inputs.
   assign r_lo = 16'(i_mem_rdata >> {off_q, 3'b000});

   always_comb begin
      ld_ext = i_mem_rdata;
      case (f3_q)
         3'b000:  ld_ext = {{24{r_lo[7]}}, r_lo[7:0]};
         3'b100:  ld_ext = {24'd0, r_lo[7:0]};
         3'b001:  ld_ext = {{16{r_lo[15]}}, r_lo};
         3'b101:  ld_ext = {16'd0, r_lo};
         default: ld_ext = i_mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      f3_d    = f3_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_lsu_valid) begin
               if (dec_err) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  ld_d    = 32'd0;
               end else begin
                  state_d = S_ACCESS;
                  cnt_d   = CW'(1);
                  off_d   = a_lo;
                  f3_d    = i_funct3;
                  req_d   = 1'b1;
                  we_d    = i_lsu_wren;
                  addr_d  = {i_alu_data[31:2], 2'b00};
                  be_d    = dec_be;
                  wdata_d = i_lsu_wren ? (i_st_data << {a_lo, 3'b000}) : 32'd0;
               end
            end
         end
         S_ACCESS: begin
            if (i_mem_ack || cnt_q == CW'(TIMEOUT)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = ~i_mem_ack;
               ld_d    = (i_mem_ack && !we_q) ? ld_ext : 32'd0;
               cnt_d   = '0;
               req_d   = 1'b0;
               we_d    = 1'b0;
               addr_d  = 32'd0;
               be_d    = 4'd0;
               wdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         ld_q    <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_lsu_stall = i_lsu_valid & ~done_q;
   assign o_lsu_done  = done_q;
   assign o_ld_data   = ld_q;
   assign o_lsu_err   = err_q;
   assign o_mem_req   = req_q;
   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_be    = be_q;
   assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset-mid-access sequence, randomized traffic vs a reference model.
module tb_lsu_ctrl;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        i_rst_n, i_lsu_valid, i_lsu_wren, i_mem_ack;
   logic [2:0]  i_funct3;
   logic [31:0] i_alu_data, i_st_data, i_mem_rdata;
   logic        o_lsu_stall, o_lsu_done, o_lsu_err, o_mem_req, o_mem_we;
   logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;

   always #5 clk = ~clk;

   lsu_ctrl #(.TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_lsu_valid(i_lsu_valid), .i_lsu_wren(i_lsu_wren),
      .i_funct3(i_funct3), .i_alu_data(i_alu_data), .i_st_data(i_st_data),
      .o_lsu_stall(o_lsu_stall), .o_lsu_done(o_lsu_done), .o_ld_data(o_ld_data),
      .o_lsu_err(o_lsu_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
   );

   int n_tot  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   typedef struct {
      logic        wren;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] st;
      logic [31:0] rdata;
      int          dly;    // ACCESS cycle carrying the ack; > TO means never
      logic        ok;     // decodes legally and aligned
      logic        err;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } vec_t;

   function automatic vec_t model(input vec_t v);
      vec_t    r = v;
      int      off, size;
      bit      legal;
      longint  val;
      off   = int'(v.addr % 4);
      size  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
      legal = v.wren ? (v.f3 <= 3'd2) : (v.f3 <= 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
      r.ok    = legal && (v.addr % size == 0);
      r.err   = !r.ok || (v.dly > TO);
      r.maddr = v.addr - off;
      r.be    = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
      r.wdata = v.wren ? (v.st << (8 * off)) : 32'd0;
      r.ld    = 32'd0;
      if (!r.err && !v.wren) begin
         val = longint'(v.rdata >> (8 * off)) % (longint'(1) << (8 * size));
         if (!v.f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
         r.ld = 32'(val);
      end
      return r;
   endfunction

   task automatic run(input vec_t e, input bit drop);
      i_lsu_valid = 1'b1;
      i_lsu_wren  = e.wren;
      i_funct3    = e.f3;
      i_alu_data  = e.addr;
      i_st_data   = e.st;
      #1;
      chk("stall_at_request", o_lsu_stall, 1);
      chk("req_before_access", o_mem_req, 0);
      @(posedge clk); #1;
      if (e.ok) begin
         for (int k = 1; k <= TO; k++) begin
            if (drop && k == 2) begin
               i_lsu_valid = 1'b0;
               i_alu_data  = $urandom;
               i_st_data   = $urandom;
            end
            #1;
            chk("access_req", o_mem_req, 1);
            chk("access_we", o_mem_we, e.wren);
            chk("access_addr", o_mem_addr, e.maddr);
            chk("access_be", o_mem_be, e.be);
            chk("access_wdata", o_mem_wdata, e.wdata);
            chk("access_done", o_lsu_done, 0);
            chk("access_stall", o_lsu_stall, i_lsu_valid);
            i_mem_ack   = (k == e.dly);
            i_mem_rdata = (k == e.dly) ? e.rdata : $urandom;
            @(posedge clk); #1;
            i_mem_ack = 1'b0;
            if (k == e.dly) break;
         end
      end
      chk("done_pulse", o_lsu_done, 1);
      chk("done_err", o_lsu_err, e.err);
      chk("done_ld", o_ld_data, e.ld);
      chk("done_req", o_mem_req, 0);
      chk("done_stall", o_lsu_stall, 0);
      // stray ack during DONE must be ignored
      i_mem_ack   = 1'b1;
      i_lsu_valid = 1'b0;
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      chk("after_done", o_lsu_done, 0);
      chk("after_req", o_mem_req, 0);
      chk("ld_hold", o_ld_data, e.ld);
   endtask

   vec_t tbl[11];
   vec_t v;

   initial begin
      //        wren f3      addr          st            rdata         dly ok err maddr         be      wdata         ld
      tbl[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 1, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1, 1, 0, 32'h200, 4'b1000, 32'h0,        32'hFFFFFF80};
      tbl[2]  = '{0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 2, 1, 0, 32'h200, 4'b1000, 32'h0,        32'h00000080};
      tbl[3]  = '{0, 3'b001, 32'h202, 32'h0,        32'h80FF1234, 1, 1, 0, 32'h200, 4'b1100, 32'h0,        32'hFFFF80FF};
      tbl[4]  = '{1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        1, 1, 0, 32'h100, 4'b1100, 32'hABCD0000, 32'h0};
      tbl[5]  = '{1, 3'b000, 32'h101, 32'h00000012, 32'h0,        1, 1, 0, 32'h100, 4'b0010, 32'h00001200, 32'h0};
      tbl[6]  = '{0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
      tbl[7]  = '{1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
      tbl[8]  = '{0, 3'b010, 32'h300, 32'h0,        32'h12345678, 4, 1, 0, 32'h300, 4'b1111, 32'h0,        32'h12345678};
      tbl[9]  = '{0, 3'b101, 32'h200, 32'h0,        32'h0,        9, 1, 1, 32'h200, 4'b0011, 32'h0,        32'h0};
      tbl[10] = '{0, 3'b101, 32'h202, 32'h0,        32'h80FF1234, 3, 1, 0, 32'h200, 4'b1100, 32'h0,        32'h000080FF};

      i_rst_n = 1'b0; i_lsu_valid = 1'b0; i_lsu_wren = 1'b0; i_funct3 = 3'd0;
      i_alu_data = 32'd0; i_st_data = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", o_mem_req, 0);
      chk("rst_we", o_mem_we, 0);
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_be", o_mem_be, 0);
      chk("rst_wdata", o_mem_wdata, 0);
      chk("rst_done", o_lsu_done, 0);
      chk("rst_err", o_lsu_err, 0);
      chk("rst_ld", o_ld_data, 0);
      chk("rst_stall", o_lsu_stall, 0);
      i_rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run(tbl[i], 1'b0);

      // reset in the second ACCESS cycle, then a stray ack
      i_lsu_valid = 1'b1; i_lsu_wren = 1'b1; i_funct3 = 3'b010;
      i_alu_data = 32'h100; i_st_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_req", o_mem_req, 1);
      i_rst_n = 1'b0;
      i_lsu_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_req", o_mem_req, 0);
      chk("mid_rst_we", o_mem_we, 0);
      chk("mid_rst_addr", o_mem_addr, 0);
      chk("mid_rst_be", o_mem_be, 0);
      chk("mid_rst_wdata", o_mem_wdata, 0);
      chk("mid_rst_done", o_lsu_done, 0);
      chk("mid_rst_ld", o_ld_data, 0);
      chk("mid_rst_stall", o_lsu_stall, 0);
      i_rst_n = 1'b1;
      i_mem_ack = 1'b1;
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      chk("stray_ack_done", o_lsu_done, 0);
      @(posedge clk); #1;
      chk("stray_ack_done2", o_lsu_done, 0);
      chk("stray_ack_req", o_mem_req, 0);
      run(tbl[0], 1'b0);

      for (int n = 0; n < 300; n++) begin
         v = tbl[0];
         v.wren  = 1'($urandom);
         v.f3    = 3'($urandom_range(0, 7));
         v.addr  = $urandom;
         v.st    = $urandom;
         v.rdata = $urandom;
         v.dly   = int'($urandom_range(1, TO + 2));
         v = model(v);
         run(v, 1'($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
